// File: rtl/mem_arbiter.sv
// Purpose: serializes the core's data and fetch requests onto one physical memory port and returns a joined response.
// Latency: the responses rise together 1 + (number of physical accesses * memory latency) cycles after the request is sampled in IDLE.
// Backpressure: the core holds its requests until the responses arrive; each physical request is held until pmem_resp; at least one IDLE cycle follows every RESP.
// Optional feature: define MEM_ARB_RMW_EN for word-only physical memory (partial-lane stores become read-modify-write).
module mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  input  logic [15:0] imem_address,
  input  logic        imem_read,
  output logic [15:0] imem_rdata,
  output logic        imem_resp,
  output logic [15:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    D_ACC    = 3'd1,
    D_RMW_RD = 3'd2,
    D_RMW_WR = 3'd3,
    I_ACC    = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t state;
  logic   d_pend;
  logic   i_pend;
  logic   data_req;

  assign data_req = mem_read | mem_write;

`ifdef MEM_ARB_RMW_EN
  // Word read during D_RMW_RD, merged with the store lanes in D_RMW_WR.
  logic [15:0] rmw_word;
  logic [15:0] word_addr;
  logic [15:0] merged_word;
  logic        partial_wr;

  assign word_addr   = {mem_address[15:1], 1'b0};
  assign partial_wr  = mem_write && (mem_byte_enable != 2'b11);
  assign merged_word = {mem_byte_enable[1] ? mem_wdata[15:8] : rmw_word[15:8],
                        mem_byte_enable[0] ? mem_wdata[7:0]  : rmw_word[7:0]};
`endif

  // Sequencer: data access first, then fetch, then a one-cycle joined response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      d_pend     <= 1'b0;
      i_pend     <= 1'b0;
      mem_rdata  <= 16'h0000;
      imem_rdata <= 16'h0000;
      mem_resp   <= 1'b0;
      imem_resp  <= 1'b0;
`ifdef MEM_ARB_RMW_EN
      rmw_word   <= 16'h0000;
`endif
    end else begin
      // Responses are single-cycle pulses; they are only set on entry to RESP.
      mem_resp  <= 1'b0;
      imem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            d_pend <= 1'b1;
            i_pend <= imem_read;
`ifdef MEM_ARB_RMW_EN
            state  <= partial_wr ? D_RMW_RD : D_ACC;
`else
            state  <= D_ACC;
`endif
          end else if (imem_read) begin
            d_pend <= 1'b0;
            i_pend <= 1'b1;
            state  <= I_ACC;
          end
        end
        D_ACC: begin
          if (pmem_resp) begin
            if (mem_read) begin
              mem_rdata <= pmem_rdata;
            end
            if (i_pend) begin
              state <= I_ACC;
            end else begin
              state     <= RESP;
              mem_resp  <= d_pend;
              imem_resp <= i_pend;
            end
          end
        end
`ifdef MEM_ARB_RMW_EN
        D_RMW_RD: begin
          if (pmem_resp) begin
            rmw_word <= pmem_rdata;
            state    <= D_RMW_WR;
          end
        end
        D_RMW_WR: begin
          if (pmem_resp) begin
            if (i_pend) begin
              state <= I_ACC;
            end else begin
              state     <= RESP;
              mem_resp  <= d_pend;
              imem_resp <= i_pend;
            end
          end
        end
`endif
        I_ACC: begin
          if (pmem_resp) begin
            imem_rdata <= pmem_rdata;
            state      <= RESP;
            mem_resp   <= d_pend;
            imem_resp  <= i_pend;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Physical port: decoded from the state and the core's held request inputs.
  always_comb begin
    pmem_address     = 16'h0000;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_wdata       = 16'h0000;
    pmem_byte_enable = 2'b00;
    case (state)
      D_ACC: begin
        pmem_address     = mem_address;
        pmem_read        = mem_read;
        pmem_write       = mem_write;
        pmem_wdata       = mem_wdata;
`ifdef MEM_ARB_RMW_EN
        pmem_byte_enable = 2'b11;
`else
        pmem_byte_enable = mem_byte_enable;
`endif
      end
`ifdef MEM_ARB_RMW_EN
      D_RMW_RD: begin
        pmem_address     = word_addr;
        pmem_read        = 1'b1;
        pmem_byte_enable = 2'b11;
      end
      D_RMW_WR: begin
        pmem_address     = word_addr;
        pmem_write       = 1'b1;
        pmem_wdata       = merged_word;
        pmem_byte_enable = 2'b11;
      end
`endif
      I_ACC: begin
        pmem_address     = imem_address;
        pmem_read        = 1'b1;
        pmem_byte_enable = 2'b11;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: the bench plays the physical memory with a per-access latency k
// and predicts the physical access list, response cycle and read results from a word-array model.
module tb_mem_arbiter;

`ifdef MEM_ARB_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_byte_enable;
  logic [15:0] imem_address, imem_rdata;
  logic        imem_read, imem_resp;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [1:0]  pmem_byte_enable;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } acc_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] phys_mem [0:32767];
  logic [15:0] ref_mem  [0:32767];
  acc_t exp_q[$];
  acc_t got_q[$];
  int   cur_k    = 1;
  int   acc_cnt  = 0;
  bit   auto_resp = 1'b1;

  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] nw, logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  // One clock: advance past the edge, then act as physical memory for this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (!auto_resp) return;
    if (pmem_read || pmem_write) acc_cnt++;
    else acc_cnt = 0;
    if (acc_cnt != 0 && acc_cnt == cur_k) begin
      pmem_resp  = 1'b1;
      pmem_rdata = phys_mem[pmem_address[15:1]];
      got_q.push_back('{pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable});
      if (pmem_write)
        phys_mem[pmem_address[15:1]] = merge(phys_mem[pmem_address[15:1]], pmem_wdata, pmem_byte_enable);
      acc_cnt = 0;
    end else begin
      pmem_resp  = 1'b0;
      pmem_rdata = 16'($urandom);
    end
  endtask

  task automatic set_word(input logic [15:0] addr, input logic [15:0] val);
    phys_mem[addr[15:1]] = val;
    ref_mem[addr[15:1]]  = val;
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after RESP.
  task automatic run_txn(input string name, input bit drd, input bit dwr, input logic [1:0] be,
                         input logic [15:0] maddr, input logic [15:0] wdata,
                         input bit ird, input logic [15:0] iaddr, input int k);
    logic [15:0] prev_m, prev_i, exp_m, exp_i, old;
    logic [14:0] w;
    int  e;
    bit  resp_bad, hold_bad, idle_bad;
    int  bad_c;
    logic bad_mr, bad_ir;
    bit  d;
    d = drd | dwr;
    mem_read = drd; mem_write = dwr; mem_byte_enable = be;
    mem_address = maddr; mem_wdata = wdata;
    imem_read = ird; imem_address = iaddr;
    cur_k = k; acc_cnt = 0;
    got_q.delete(); exp_q.delete();
    prev_m = mem_rdata; prev_i = imem_rdata;
    exp_m = prev_m; exp_i = prev_i;
    // Reference model: list of physical accesses and the data they yield.
    if (d) begin
      w = maddr[15:1];
      if (RMW && dwr && be != 2'b11) begin
        old = ref_mem[w];
        exp_q.push_back('{{w, 1'b0}, 1'b1, 1'b0, 16'h0000, 2'b11});
        exp_q.push_back('{{w, 1'b0}, 1'b0, 1'b1, merge(old, wdata, be), 2'b11});
        ref_mem[w] = merge(old, wdata, be);
      end else begin
        exp_q.push_back('{maddr, drd, dwr, wdata, RMW ? 2'b11 : be});
        if (drd) exp_m = ref_mem[w];
        if (dwr) ref_mem[w] = merge(ref_mem[w], wdata, RMW ? 2'b11 : be);
      end
    end
    if (ird) begin
      exp_q.push_back('{iaddr, 1'b1, 1'b0, 16'h0000, 2'b11});
      exp_i = ref_mem[iaddr[15:1]];
    end
    e = 1 + exp_q.size() * k;
    resp_bad = 0; hold_bad = 0; idle_bad = 0; bad_c = 0; bad_mr = 0; bad_ir = 0;
    for (int c = 1; c <= e + 1; c++) begin
      step();
      if (mem_resp !== ((c == e) && d) || imem_resp !== ((c == e) && ird)) begin
        if (!resp_bad) begin bad_c = c; bad_mr = mem_resp; bad_ir = imem_resp; end
        resp_bad = 1;
      end
      if (c < e && imem_rdata !== prev_i) hold_bad = 1;
      if (c >= e && (pmem_read !== 1'b0 || pmem_write !== 1'b0)) idle_bad = 1;
    end
    n_checks++;
    if (resp_bad) $display("FAIL %s resp_timing: cycle %0d mem_resp=%b imem_resp=%b, expected pulse only in cycle %0d (d=%b i=%b)",
                           name, bad_c, bad_mr, bad_ir, e, d, ird);
    else n_pass++;
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s access_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    else n_pass++;
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j].addr !== exp_q[j].addr || got_q[j].rd !== exp_q[j].rd || got_q[j].wr !== exp_q[j].wr ||
          got_q[j].be !== exp_q[j].be || (exp_q[j].wr && got_q[j].wdata !== exp_q[j].wdata))
        $display("FAIL %s access%0d: got a=%h r=%b w=%b d=%h be=%b expected a=%h r=%b w=%b d=%h be=%b",
                 name, j, got_q[j].addr, got_q[j].rd, got_q[j].wr, got_q[j].wdata, got_q[j].be,
                 exp_q[j].addr, exp_q[j].rd, exp_q[j].wr, exp_q[j].wdata, exp_q[j].be);
      else n_pass++;
    end
    n_checks++;
    if (mem_rdata !== exp_m) $display("FAIL %s mem_rdata: got %h expected %h", name, mem_rdata, exp_m);
    else n_pass++;
    n_checks++;
    if (imem_rdata !== exp_i) $display("FAIL %s imem_rdata: got %h expected %h", name, imem_rdata, exp_i);
    else n_pass++;
    n_checks++;
    if (hold_bad) $display("FAIL %s imem_rdata_hold: changed before fetch completed, expected %h held", name, prev_i);
    else n_pass++;
    n_checks++;
    if (idle_bad) $display("FAIL %s pmem_idle_after: request active in RESP/IDLE, expected none", name);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; mem_byte_enable = 2'b11;
    mem_address = 16'h1234; mem_wdata = 16'h5678;
    imem_read = 1'b1; imem_address = 16'h0100;
    pmem_resp = 1'b0; pmem_rdata = 16'h0000;
    auto_resp = 1'b0;
    step(); step(); step();
    n_checks++;
    if ({mem_resp, imem_resp, pmem_read, pmem_write} !== 4'b0000)
      $display("FAIL reset_ctrl: got resp=%b%b pmem rd/wr=%b%b expected 0000", mem_resp, imem_resp, pmem_read, pmem_write);
    else n_pass++;
    n_checks++;
    if ({pmem_address, pmem_wdata, pmem_byte_enable} !== 34'h0)
      $display("FAIL reset_pmem: got a=%h d=%h be=%b expected zeros", pmem_address, pmem_wdata, pmem_byte_enable);
    else n_pass++;
    n_checks++;
    if ({mem_rdata, imem_rdata} !== 32'h0)
      $display("FAIL reset_rdata: got %h %h expected 0000 0000", mem_rdata, imem_rdata);
    else n_pass++;
    mem_read = 1'b0; imem_read = 1'b0;
    reset_n = 1'b1;
    auto_resp = 1'b1;
    step();
  endtask

  task automatic test_fetch_only();
    set_word(16'h0040, 16'h1234);
    run_txn("fetch_only", 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b1, 16'h0040, 3);
    n_checks++;
    if (imem_rdata !== 16'h1234) $display("FAIL fetch_only_value: got %h expected 1234", imem_rdata);
    else n_pass++;
    imem_read = 1'b0;
  endtask

  task automatic test_load_fetch();
    set_word(16'h2000, 16'hBEEF);
    set_word(16'h0042, 16'h5A5A);
    run_txn("load_fetch", 1'b1, 1'b0, 2'b11, 16'h2000, 16'h0000, 1'b1, 16'h0042, 1);
    n_checks++;
    if ({mem_rdata, imem_rdata} !== 32'hBEEF_5A5A)
      $display("FAIL load_fetch_values: got %h %h expected beef 5a5a", mem_rdata, imem_rdata);
    else n_pass++;
    mem_read = 1'b0; imem_read = 1'b0;
  endtask

  task automatic test_byte_store();
    logic [15:0] m;
    set_word(16'h3000, 16'h1122);
    run_txn("byte_store", 1'b0, 1'b1, 2'b10, 16'h3001, 16'hAB00, 1'b0, 16'h0000, 2);
    m = phys_mem[16'h1800];
    n_checks++;
    if (m !== 16'hAB22) $display("FAIL byte_store_memory: got %h expected ab22", m);
    else n_pass++;
    mem_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_word(16'h0060, 16'h0F0F);
    run_txn("b2b_first", 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b1, 16'h0060, 2);
    set_word(16'h0060, 16'hC3C3);
    run_txn("b2b_second", 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b1, 16'h0060, 2);
    imem_read = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    set_word(16'h2200, 16'h7777);
    set_word(16'h0070, 16'h8888);
    run_txn("pre_reset", 1'b1, 1'b0, 2'b11, 16'h2200, 16'h0000, 1'b1, 16'h0070, 1);
    cur_k = 1000; acc_cnt = 0;
    mem_read = 1'b1; mem_address = 16'h2200;
    step();  // cycle 1: first D_ACC cycle
    step();  // cycle 2: second D_ACC cycle
    n_checks++;
    if (pmem_read !== 1'b1) $display("FAIL mid_access_live: got pmem_read=%b expected 1", pmem_read);
    else n_pass++;
    reset_n = 1'b0;
    step();
    n_checks++;
    if ({pmem_read, pmem_write, mem_resp, imem_resp} !== 4'b0000)
      $display("FAIL mid_reset_ctrl: got rd=%b wr=%b resp=%b%b expected 0000", pmem_read, pmem_write, mem_resp, imem_resp);
    else n_pass++;
    n_checks++;
    if ({mem_rdata, imem_rdata} !== 32'h0)
      $display("FAIL mid_reset_rdata: got %h %h expected 0000 0000", mem_rdata, imem_rdata);
    else n_pass++;
    reset_n = 1'b1;
    mem_read = 1'b0; imem_read = 1'b0;
    auto_resp = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    step();
    pmem_resp = 1'b0;
    begin
      bit bad;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (mem_resp !== 1'b0 || imem_resp !== 1'b0 || pmem_read !== 1'b0 || mem_rdata !== 16'h0) bad = 1;
        step();
      end
      n_checks++;
      if (bad) $display("FAIL late_pmem_resp: got resp=%b%b rdata=%h expected no response and rdata 0000", mem_resp, imem_resp, mem_rdata);
      else n_pass++;
    end
    auto_resp = 1'b1; acc_cnt = 0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      int kind;
      bit drd, dwr, ird;
      logic [1:0]  be;
      logic [15:0] ma, ia;
      kind = $urandom_range(0, 4);
      drd = (kind == 0 || kind == 3);
      dwr = (kind == 1 || kind == 4);
      ird = (kind >= 2);
      be  = 2'b11;
      ma  = 16'h1000 + 16'(2 * $urandom_range(0, 15));
      if (dwr) begin
        be = 2'($urandom_range(1, 3));
        if (be == 2'b10) ma[0] = 1'b1;
      end
      ia = 16'h1000 + 16'(2 * $urandom_range(0, 15));
      run_txn($sformatf("rand%0d", t), drd, dwr, be, ma, 16'($urandom), ird, ia, $urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        mem_read = 1'b0; mem_write = 1'b0; imem_read = 1'b0;
        step();
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; imem_read = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      phys_mem[i] = 16'(i * 40503 + 7);
      ref_mem[i]  = 16'(i * 40503 + 7);
    end
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_byte_store();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the pipelined LC-3b core. It accepts the core's data-port (`mem_*`) and instruction-port (`imem_*`) requests and serializes them onto one physical memory port (`pmem_*`). It returns a joined response: `mem_resp` and `imem_resp` rise together in one cycle, because the core advances only when both ports are satisfied. It sits between the core and the physical memory/cache.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous, active-low reset
- `mem_address`  in  16  data byte address
- `mem_wdata`  in  16  store data; a byte store carries the byte in its own lane
- `mem_read` / `mem_write`  in  1  data request, held until `mem_resp`
- `mem_byte_enable`  in  2  lane enables, [1] = high byte
- `mem_rdata`  out  16  registered data-read result
- `mem_resp`  out  1  data response pulse
- `imem_address`  in  16  fetch address
- `imem_read`  in  1  fetch request, held until `imem_resp`
- `imem_rdata`  out  16  registered fetch result
- `imem_resp`  out  1  fetch response pulse
- `pmem_address`  out  16  physical address
- `pmem_read` / `pmem_write`  out  1  physical request, held until `pmem_resp`
- `pmem_wdata`  out  16  physical write data
- `pmem_byte_enable`  out  2  physical lane enables
- `pmem_rdata`  in  16  physical read data, valid with `pmem_resp`
- `pmem_resp`  in  1  one-cycle completion pulse

## Operation
**FSM states:** IDLE, D_ACC, D_RMW_RD, D_RMW_WR, I_ACC, RESP.

**Latched flags:** `d_pend = mem_read|mem_write` and `i_pend = imem_read`, both captured on leaving IDLE.

**Transitions:**
- IDLE:
  - `d_pend` set → D_ACC, or → D_RMW_RD for a partial-lane write when RMW is enabled.
  - else `i_pend` set → I_ACC.
  - else stay in IDLE.
- D_ACC:
  - drive `pmem_address = mem_address`, `pmem_read = mem_read`, `pmem_write = mem_write`, `pmem_wdata = mem_wdata`, `pmem_byte_enable = mem_byte_enable`.
  - on `pmem_resp`: a read latches `pmem_rdata` into `mem_rdata`; then → I_ACC if `i_pend`, else → RESP.
- I_ACC:
  - drive `pmem_address = imem_address`, `pmem_read = 1`, `pmem_byte_enable = 11`.
  - on `pmem_resp`: latch `pmem_rdata` into `imem_rdata`; → RESP.
- RESP:
  - `mem_resp = d_pend`, `imem_resp = i_pend`, both for exactly one cycle; → IDLE.

**Ordering:** the data access always precedes the fetch when both are pending (fixed priority).

**Pass-through rules:**
- `pmem_*` are Moore outputs of the state combined with the core's held inputs.
- `pmem_read`, `pmem_write` = 0 in IDLE and RESP.
- `mem_rdata` / `imem_rdata` hold their value until overwritten by a later read.
- A data write leaves `mem_rdata` unchanged.

**Request stability:** the core's inputs are stable from IDLE through RESP, so no re-sampling is needed. Changes mid-transaction are a protocol violation and are not checked.

## Timing
**Reset (`reset_n = 0` at an edge):**
- state → IDLE; `mem_rdata`, `imem_rdata`, `d_pend`, `i_pend` → 0.
- `mem_resp`, `imem_resp`, `pmem_read`, `pmem_write` = 0.
- `pmem_address`, `pmem_wdata` = 0; `pmem_byte_enable` = 00.

**Latency:** requests are sampled in IDLE (cycle 0). With `pmem_resp` arriving in the k-th cycle of each access (k≥1):
- single-port response high in cycle 1+k;
- data+fetch response high in cycle 1+2k;
- RMW adds one extra physical access.

**Back-to-back:** at least one IDLE cycle separates RESP from the next physical request.

**Reset mid-access:** requests drop on the next cycle. A `pmem_resp` arriving in IDLE is ignored, and physical memory must tolerate the abandoned request.

**Indirect loads:** the second data access of an indirect load re-runs the full sequence, including a repeat fetch; this is correct behaviour.

## Configuration
- `MEM_ARB_RMW_EN` defined:
  - physical memory is word-only; `pmem_byte_enable` is always 11 during a request.
  - a write with `mem_byte_enable` ≠ 11 runs D_RMW_RD (read word at `{mem_address[15:1],0}`, latch it into an internal holding register).
  - then D_RMW_WR (write the merged word: enabled lanes from `mem_wdata`, other lanes from the read word).
  - then → I_ACC/RESP as from D_ACC.
- `MEM_ARB_RMW_EN` undefined: D_RMW_* are unreachable, and `mem_byte_enable` passes straight through in D_ACC.

## Test plan
- Fetch only, k=3, `imem_address` 0x0040, pmem returns 0x1234 → `imem_resp` high only in cycle 4, `imem_rdata` = 0x1234, `mem_resp` stays 0.
- Load + fetch, k=1, `mem_address` 0x2000 → 0xBEEF, `imem_address` 0x0042 → 0x5A5A:
  - pmem sees 0x2000 then 0x0042;
  - both resps high together in cycle 3 only; `mem_rdata` = 0xBEEF, `imem_rdata` = 0x5A5A.
- Byte store, word at 0x3000 = 0x1122, `mem_address` 0x3001, BE 10, `mem_wdata` 0xAB00:
  - with `MEM_ARB_RMW_EN`: pmem read 0x3000, then write 0xAB22 with BE 11;
  - without it: a single write, BE 10, data 0xAB00.
- `reset_n` low in the second cycle of D_ACC → next cycle `pmem_read` = 0, resps = 0, rdata regs = 0; a late `pmem_resp` causes no response.
- Requests held after RESP → one IDLE cycle, then a new D_ACC/I_ACC; `imem_rdata` holds its previous value until the new fetch's `pmem_resp`.
